ts_write_scheduler: RTL and testbench

Sequences timestamp storage for the profiling counter kernel. Consumes the 4-bit command stream generated from the OpenCL pipe, captures a free-running cycle counter on every save command, buffers captures in a small FIFO and drains them to memory through a single-outstanding write request/acknowledge port. Sits between the pipe command decoder and the memory write master; signals completion once a finish command has been received and all buffered timestamps are written.

---
 rtl/ts_sched_pkg.sv | 22 ++
 rtl/ts_write_scheduler_if.sv | 16 +
 rtl/ts_fifo.sv | 67 ++++++
 rtl/ts_write_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_ts_write_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_sched_pkg.sv
// Shared constants and types for the timestamp write scheduler.
// Command encodings, FSM state type and the per-entry address step.
package ts_sched_pkg;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_SAVE   = 4'h1;
  localparam logic [3:0] CMD_FINISH = 4'h2;

  localparam int unsigned TS_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Byte offset of a given entry index from the session base address.
  function automatic logic [31:0] entry_offset(input logic [31:0] idx);
    return idx * TS_BYTES;
  endfunction

endpackage

// File: rtl/ts_write_scheduler_if.sv
// Single-outstanding memory write request/acknowledge port.
// The scheduler drives the request side through the master modport.
interface ts_write_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int TS_W   = 64
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [TS_W-1:0]   wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/ts_fifo.sv
// Synchronous DEPTH x W FIFO with registered occupancy and a synchronous clear.
// Pushes while full and pops while empty are ignored; clear has priority.
module ts_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full & ~clr;
  assign do_pop_s  = pop & ~empty & ~clr;

  // Storage array write port; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ts_write_scheduler.sv
// Captures a free-running cycle counter on save commands and drains the captures to memory.
// Optional TS_SCHED_DROP_CNT_EN adds a saturating drop_count output.
module ts_write_scheduler
  import ts_sched_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 64,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [31:0]          max_entries,
  input  logic [3:0]           command,
  output logic                 done,
  ts_write_scheduler_if.master wr,
  output logic [31:0]          wr_count,
  output logic                 overflow
`ifdef TS_SCHED_DROP_CNT_EN
  ,
  output logic [31:0]          drop_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state_r;
  state_t            state_next_s;
  logic [TS_W-1:0]   ts_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       max_r;
  logic [31:0]       cap_total_r;
  logic [31:0]       wr_count_r;
  logic              overflow_r;
  logic              done_r;
  logic              wr_req_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [TS_W-1:0]   wr_data_r;

  logic              start_acc_s;
  logic              accept_s;
  logic              drop_s;
  logic              pop_s;
  logic              ack_s;
  logic [TS_W-1:0]   fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;

  assign ack_s      = wr_req_r & wr.wr_ack;
  assign done       = done_r;
  assign wr_count   = wr_count_r;
  assign overflow   = overflow_r;
  assign wr.wr_req  = wr_req_r;
  assign wr.wr_addr = wr_addr_r;
  assign wr.wr_data = wr_data_r;

  ts_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc_s),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (ts_r),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_cnt_s)
  );

  // Next-state, capture acceptance and writer pop decision.
  always_comb begin
    state_next_s = state_r;
    start_acc_s  = 1'b0;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          start_acc_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (command == CMD_FINISH) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
        // Fullness is the start-of-cycle occupancy: a same-cycle pop frees nothing.
        if (command == CMD_SAVE) begin
          if (!fifo_full_s && (cap_total_r < max_r)) begin
            accept_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
        pop_s = ~wr_req_r & ~fifo_empty_s;
      end
      DRAIN: begin
        if ((fifo_cnt_s == {CNT_W{1'b0}}) && !wr_req_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
        pop_s = ~wr_req_r & ~fifo_empty_s;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == IDLE);
    end
  end

  // Free-running timestamp counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= {TS_W{1'b0}};
    end else if (start_acc_s) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1'b1);
    end
  end

  // Session configuration and bookkeeping counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r      <= {ADDR_W{1'b0}};
      max_r       <= 32'd0;
      cap_total_r <= 32'd0;
      wr_count_r  <= 32'd0;
      overflow_r  <= 1'b0;
    end else if (start_acc_s) begin
      base_r      <= base_addr;
      max_r       <= max_entries;
      cap_total_r <= 32'd0;
      wr_count_r  <= 32'd0;
      overflow_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        cap_total_r <= cap_total_r + 32'd1;
      end
      if (ack_s) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Write request port: load on pop, hold until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_r  <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {TS_W{1'b0}};
    end else if (pop_s) begin
      wr_req_r  <= 1'b1;
      wr_addr_r <= base_r + ADDR_W'(entry_offset(wr_count_r));
      wr_data_r <= fifo_dout_s;
    end else if (ack_s) begin
      wr_req_r  <= 1'b0;
    end
  end

`ifdef TS_SCHED_DROP_CNT_EN
  logic [31:0] drop_cnt_r;

  assign drop_count = drop_cnt_r;

  // Saturating count of dropped saves this session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      drop_cnt_r <= 32'd0;
    end else if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ts_write_scheduler.sv
// Directed bench for ts_write_scheduler (DEPTH=4) with a write-port responder and scoreboard.
module tb_ts_write_scheduler;
  import ts_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] max_entries;
  logic [3:0]  command;
  logic        done;
  logic [31:0] wr_count;
  logic        overflow;
`ifdef TS_SCHED_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  ts_write_scheduler_if #(.ADDR_W(32), .TS_W(64)) wr_if ();

  ts_write_scheduler #(.DEPTH(4), .TS_W(64), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .max_entries (max_entries),
    .command     (command),
    .done        (done),
    .wr          (wr_if),
    .wr_count    (wr_count),
    .overflow    (overflow)
`ifdef TS_SCHED_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_addr[$];
  logic [63:0] sb_data[$];
  logic [63:0] ts_m;
  logic [31:0] exp_base;
  int          exp_idx;
  logic        ack_en;
  int          ack_delay;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts_m = ts_m + 64'd1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] maxe);
    start       = 1'b1;
    base_addr   = base;
    max_entries = maxe;
    step();
    start    = 1'b0;
    ts_m     = 64'd0;
    exp_base = base;
    exp_idx  = 0;
  endtask

  task automatic save(input logic accept);
    command = CMD_SAVE;
    if (accept) begin
      sb_addr.push_back(exp_base + 32'(exp_idx * 8));
      sb_data.push_back(ts_m);
      exp_idx++;
    end
    step();
    command = CMD_NOP;
  endtask

  task automatic finish_cmd();
    command = CMD_FINISH;
    step();
    command = CMD_NOP;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (done) break;
      step();
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_count(input string tag, input logic [31:0] n, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (wr_count == n) break;
      step();
    end
    chk(tag, 64'(wr_count), 64'(n));
  endtask

  // Write-port responder: checks each request against the scoreboard and acks it.
  initial begin
    logic [31:0] hold_addr;
    logic [63:0] hold_data;
    logic        seen;
    int          age;
    wr_if.wr_ack = 1'b0;
    seen = 1'b0;
    age  = 0;
    hold_addr = 32'd0;
    hold_data = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_if.wr_ack = 1'b0;
        seen = 1'b0;
      end else if (wr_if.wr_ack) begin
        wr_if.wr_ack = 1'b0;
        seen = 1'b0;
      end else if (wr_if.wr_req && ack_en) begin
        if (!seen) begin
          seen = 1'b1;
          age  = 0;
          hold_addr = wr_if.wr_addr;
          hold_data = wr_if.wr_data;
          chk("sb_nonempty", 64'(sb_addr.size() != 0), 64'd1);
          if (sb_addr.size() != 0) begin
            chk("wr_addr", 64'(wr_if.wr_addr), 64'(sb_addr.pop_front()));
            chk("wr_data", wr_if.wr_data, sb_data.pop_front());
          end
        end else begin
          age++;
          chk("addr_stable", 64'(wr_if.wr_addr), 64'(hold_addr));
          chk("data_stable", wr_if.wr_data, hold_data);
        end
        if (age >= ack_delay) wr_if.wr_ack = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; max_entries = 32'd0;
    command = CMD_NOP; ack_en = 1'b1; ack_delay = 1; ts_m = 64'd0;
    exp_base = 32'd0; exp_idx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_done",     64'(done), 64'd1);
    chk("rst_wr_req",   64'(wr_if.wr_req), 64'd0);
    chk("rst_wr_addr",  64'(wr_if.wr_addr), 64'd0);
    chk("rst_wr_data",  wr_if.wr_data, 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // Basic session: saves at counter 5 and 9, one-cycle ack
    do_start(32'h1000, 32'd8);
    chk("run_done_low", 64'(done), 64'd0);
    repeat (5) step();
    save(1'b1);
    chk("lat_t1", 64'(wr_if.wr_req), 64'd0);
    step();
    chk("lat_t2", 64'(wr_if.wr_req), 64'd1);
    repeat (2) step();
    save(1'b1);
    finish_cmd();
    wait_done("t1_done", 50);
    chk("t1_wr_count", 64'(wr_count), 64'd2);
    chk("t1_overflow", 64'(overflow), 64'd0);
    chk("t1_sb_empty", 64'(sb_addr.size()), 64'd0);

    // FIFO full with ack held low: 6 back-to-back saves, 5 accepted
    ack_en = 1'b0;
    do_start(32'h2000, 32'd16);
    for (int i = 0; i < 6; i++) save(i < 5);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_hold_req",  64'(wr_if.wr_req), 64'd1);
    chk("t2_hold_addr", 64'(wr_if.wr_addr), 64'h2000);
    chk("t2_hold_data", wr_if.wr_data, 64'd0);
    ack_en = 1'b1;
    finish_cmd();
    wait_done("t2_done", 100);
    chk("t2_wr_count", 64'(wr_count), 64'd5);
    chk("t2_sb_empty", 64'(sb_addr.size()), 64'd0);
`ifdef TS_SCHED_DROP_CNT_EN
    chk("t2_drop_count", 64'(drop_count), 64'd1);
`endif

    // Capture budget of 3 with 5 spaced saves
    do_start(32'h3000, 32'd3);
    chk("t3_overflow_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 5; i++) begin
      save(i < 3);
      repeat (9) step();
    end
    finish_cmd();
    wait_done("t3_done", 50);
    chk("t3_wr_count", 64'(wr_count), 64'd3);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_sb_empty", 64'(sb_addr.size()), 64'd0);
`ifdef TS_SCHED_DROP_CNT_EN
    chk("t3_drop_count", 64'(drop_count), 64'd2);
`endif

    // Finish with 3 entries buffered; saves during DRAIN ignored
    ack_en = 1'b0;
    do_start(32'h4000, 32'd8);
    for (int i = 0; i < 3; i++) save(1'b1);
    finish_cmd();
    command = CMD_SAVE;
    repeat (3) step();
    command = CMD_NOP;
    repeat (4) step();
    chk("t4_done_low", 64'(done), 64'd0);
    ack_en = 1'b1;
    wait_count("t4_cnt2", 32'd2, 50);
    chk("t4_done_low2", 64'(done), 64'd0);
    wait_done("t4_done", 50);
    chk("t4_wr_count", 64'(wr_count), 64'd3);
    chk("t4_sb_empty", 64'(sb_addr.size()), 64'd0);

    // Asynchronous reset while a request is pending
    ack_en = 1'b0;
    do_start(32'h5000, 32'd8);
    save(1'b1);
    step();
    chk("t5_req_up", 64'(wr_if.wr_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_req_async", 64'(wr_if.wr_req), 64'd0);
    chk("t5_done_async", 64'(done), 64'd1);
    sb_addr.delete();
    sb_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    ack_en = 1'b1;
    do_start(32'h6000, 32'd8);
    chk("t5_wr_count0", 64'(wr_count), 64'd0);
    repeat (3) step();
    chk("t5_fifo_empty", 64'(wr_if.wr_req), 64'd0);
    save(1'b1);
    finish_cmd();
    wait_done("t5_done", 50);
    chk("t5_wr_count", 64'(wr_count), 64'd1);

    // start in RUN and command 0x7 are ignored; counter keeps running
    do_start(32'h7000, 32'd8);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    command = 4'h7;
    repeat (3) step();
    command = CMD_NOP;
    chk("t6_still_run", 64'(done), 64'd0);
    chk("t6_no_capture", 64'(wr_if.wr_req), 64'd0);
    save(1'b1);
    finish_cmd();
    wait_done("t6_done", 50);
    chk("t6_wr_count", 64'(wr_count), 64'd1);

    // Saves in IDLE are ignored
    command = CMD_SAVE;
    repeat (3) step();
    command = CMD_NOP;
    step();
    chk("t7_idle_done", 64'(done), 64'd1);
    chk("t7_idle_req", 64'(wr_if.wr_req), 64'd0);

    // Fresh start clears the counter; finish with nothing pending completes in 2 cycles
    do_start(32'h8000, 32'd8);
    repeat (2) step();
    save(1'b1);
    wait_count("t8_cnt1", 32'd1, 50);
    finish_cmd();
    chk("t8_fin_t1", 64'(done), 64'd0);
    step();
    chk("t8_fin_t2", 64'(done), 64'd1);
    chk("t8_sb_empty", 64'(sb_addr.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
